spi_tx_arbiter: RTL

//  Shares the single SPI transmit byte path between NREQ word-sized requesters:
//  ID reply, metadata, dataIn snapshot and capture stream.

---
 rtl/spi_tx_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: grants one requester the SPI transmit byte path and serializes its
// masked 32-bit word LSB byte first through a load/done handshake.
module spi_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int RR         = 0,
    parameter int TX_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_data,
    input  logic [4*NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_load,
    input  logic                 tx_done,
    input  logic                 flush,
    output logic                 err
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int TW = TX_TIMEOUT > 0 ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TX_TIMEOUT);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t        state;
    logic [IW-1:0] ptr, win, own;
    logic          found;
    int            idx;
    logic [31:0]   word;
    logic [3:0]    mask;
    logic [1:0]    sel;
    logic [TW-1:0] timer;
    logic          timed_out;

    // Round-robin scans from the pointer with wraparound; fixed priority scans from 0.
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = RR != 0 ? (int'(ptr) + k) % NREQ : k;
            if (!found && req[idx]) begin
                win = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        sel = 2'd0;
        for (int b = 3; b >= 0; b--)
            if (mask[b]) sel = 2'(b);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            own       <= '0;
            grant     <= '0;
            req_ack   <= '0;
            busy      <= 1'b0;
            tx_data   <= '0;
            tx_load   <= 1'b0;
            err       <= 1'b0;
            word      <= '0;
            mask      <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
        end else begin
            tx_load <= 1'b0;
            req_ack <= '0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (!flush && found) begin
                        state     <= LOAD;
                        own       <= win;
                        grant     <= ONE << win;
                        busy      <= 1'b1;
                        word      <= req_data[32*win +: 32];
                        mask      <= req_valid[4*win +: 4];
                        timed_out <= 1'b0;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (flush || mask == 4'd0) begin
                        state <= DONE;
                    end else begin
                        tx_data   <= word[8*sel +: 8];
                        tx_load   <= 1'b1;
                        mask[sel] <= 1'b0;
                        timer     <= TMAX;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state <= DONE;
                    end else if (tx_done) begin
                        state <= LOAD;
                    end else if (TX_TIMEOUT > 0 && timer == TW'(1)) begin
                        state     <= DONE;
                        timed_out <= 1'b1;
                    end else if (timer != '0) begin
                        timer <= timer - TW'(1);
                    end
                end
                DONE: begin
                    req_ack <= grant;
                    err     <= timed_out;
                    ptr     <= own == IW'(NREQ - 1) ? '0 : own + IW'(1);
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
